// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame transmitter.
package serial_frame_pkg;

  // Transmitter line states, in the order they occur within a frame.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Total clocks from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_cycles(input int width, input int parity_en,
                                      input int stop_bits, input int bit_cycles);
    return (1 + width + parity_en + stop_bits) * bit_cycles;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while enabled and flags the
// terminal count so the frame FSM advances once per serial bit.
module serial_bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_tick = enable && (cnt_q == LAST);

  // Next count: restart on clear, wrap on the terminal count.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = bit_tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: start bit, WIDTH data bits MSB-first, optional
// parity bit, 1 or 2 stop bits. The serial line idles high and is registered.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dataout,
  output logic             busy,
  output logic             frame_done
);

  if ((WIDTH < 1) || (BIT_CYCLES < 1) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
      (PARITY_EN < 0) || (PARITY_EN > 1)) begin : g_bad_params
    $error("serial_frame_tx: illegal parameter combination");
  end

  localparam int   IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [IDX_W-1:0] data_idx_q, data_idx_d;
  logic [1:0]       stop_idx_q, stop_idx_d;
  logic             dataout_q, dataout_d;
  logic             frame_done_q, frame_done_d;
  logic             accept;
  logic             bit_tick;

  assign in_ready   = rst_n && (state_q == IDLE);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != IDLE);
  assign dataout    = dataout_q;
  assign frame_done = frame_done_q;

  serial_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (busy),
    .clear   (accept),
    .bit_tick(bit_tick)
  );

  // Frame sequencing: the line value for the next cycle is decided together
  // with the state transition so dataout can come straight from a flop.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    data_idx_d   = data_idx_q;
    stop_idx_d   = stop_idx_q;
    dataout_d    = dataout_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = in_data;
          parity_d  = (^in_data) ^ ODD_BIT;
          dataout_d = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d    = DATA;
          data_idx_d = IDX_W'(WIDTH - 1);
          dataout_d  = shift_q[WIDTH-1];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (data_idx_q == '0) begin
            if (PARITY_EN != 0) begin
              state_d   = PARITY;
              dataout_d = parity_q;
            end else begin
              state_d    = STOP;
              stop_idx_d = 2'(STOP_BITS);
              dataout_d  = 1'b1;
            end
          end else begin
            data_idx_d = data_idx_q - IDX_W'(1);
            shift_d    = shift_q << 1;
            dataout_d  = shift_d[WIDTH-1];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d    = STOP;
          stop_idx_d = 2'(STOP_BITS);
          dataout_d  = 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_idx_q == 2'd1) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else begin
            stop_idx_d = stop_idx_q - 2'd1;
          end
          dataout_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        dataout_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset forces the line high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      data_idx_q   <= '0;
      stop_idx_q   <= '0;
      dataout_q    <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      data_idx_q   <= data_idx_d;
      stop_idx_q   <= stop_idx_d;
      dataout_q    <= dataout_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: three configurations share one clock.
// Expected line bits are pushed to a queue at accept and popped per clock.
module tb_serial_frame_tx;
  import serial_frame_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data    [3];
  logic       in_valid   [3];
  logic       in_ready   [3];
  logic       dataout    [3];
  logic       busy       [3];
  logic       frame_done [3];

  // Per-instance configuration used by the reference model.
  int bc_a   [3] = '{1, 4, 1};
  int pen_a  [3] = '{1, 1, 0};
  int podd_a [3] = '{0, 1, 0};
  int sb_a   [3] = '{1, 1, 2};

  int   checks   = 0;
  int   failures = 0;
  logic exp_q [$];

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .BIT_CYCLES(1))
  u_dut0 (.clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
          .in_ready(in_ready[0]), .dataout(dataout[0]), .busy(busy[0]),
          .frame_done(frame_done[0]));

  serial_frame_tx #(.WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .BIT_CYCLES(4))
  u_dut1 (.clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
          .in_ready(in_ready[1]), .dataout(dataout[1]), .busy(busy[1]),
          .frame_done(frame_done[1]));

  serial_frame_tx #(.WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .BIT_CYCLES(1))
  u_dut2 (.clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
          .in_ready(in_ready[2]), .dataout(dataout[2]), .busy(busy[2]),
          .frame_done(frame_done[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one queue entry per clock of line activity.
  task automatic build(input int s, input logic [7:0] w);
    logic p;
    exp_q.delete();
    repeat (bc_a[s]) exp_q.push_back(1'b0);
    for (int i = 7; i >= 0; i--) repeat (bc_a[s]) exp_q.push_back(w[i]);
    if (pen_a[s] != 0) begin
      p = (w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4] ^ w[5] ^ w[6] ^ w[7]) ^ (podd_a[s] != 0);
      repeat (bc_a[s]) exp_q.push_back(p);
    end
    repeat (sb_a[s] * bc_a[s]) exp_q.push_back(1'b1);
  endtask

  // Pop n expected line bits, one per clock; optionally churn the inputs.
  task automatic expect_bits(input int s, input int n, input bit churn);
    logic e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("dut%0d dataout", s), dataout[s], e);
      check($sformatf("dut%0d busy", s), busy[s], 1'b1);
      check($sformatf("dut%0d frame_done_early", s), frame_done[s], 1'b0);
      check($sformatf("dut%0d in_ready_busy", s), in_ready[s], 1'b0);
      if (churn) begin
        in_data[s]  = 8'($urandom);
        in_valid[s] = (exp_q.size() != 0);
      end
    end
  endtask

  task automatic expect_idle_end(input int s);
    @(negedge clk);
    check($sformatf("dut%0d end_dataout", s), dataout[s], 1'b1);
    check($sformatf("dut%0d end_busy", s), busy[s], 1'b0);
    check($sformatf("dut%0d end_frame_done", s), frame_done[s], 1'b1);
    check($sformatf("dut%0d end_in_ready", s), in_ready[s], 1'b1);
  endtask

  task automatic expect_frame(input int s, input logic [7:0] w, input bit churn);
    int n;
    build(s, w);
    n = exp_q.size();
    check($sformatf("dut%0d model_len", s), n,
          frame_cycles(8, pen_a[s], sb_a[s], bc_a[s]));
    expect_bits(s, n, churn);
    expect_idle_end(s);
  endtask

  // Present a word at a falling edge and return just after the accepting edge.
  task automatic start_tx(input int s, input logic [7:0] w);
    @(negedge clk);
    in_data[s]  = w;
    in_valid[s] = 1'b1;
    check($sformatf("dut%0d ready_before_accept", s), in_ready[s], 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      in_data[s]  = 8'h00;
      in_valid[s] = 1'b0;
    end
    rst_n = 1'b0;
    #12;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("dut%0d rst_dataout", s), dataout[s], 1'b1);
      check($sformatf("dut%0d rst_busy", s), busy[s], 1'b0);
      check($sformatf("dut%0d rst_frame_done", s), frame_done[s], 1'b0);
      check($sformatf("dut%0d rst_in_ready", s), in_ready[s], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Default configuration, single pulse.
    start_tx(0, 8'hA5);
    in_valid[0] = 1'b0;
    expect_frame(0, 8'hA5, 1'b0);
    @(negedge clk);
    check("dut0 done_one_cycle", frame_done[0], 1'b0);

    // Slow bit rate with odd parity.
    start_tx(1, 8'hFF);
    in_valid[1] = 1'b0;
    expect_frame(1, 8'hFF, 1'b0);
    @(negedge clk);
    check("dut1 line_idle_after", dataout[1], 1'b1);
    check("dut1 done_one_cycle", frame_done[1], 1'b0);

    // No parity, two stop bits.
    start_tx(2, 8'h3C);
    in_valid[2] = 1'b0;
    expect_frame(2, 8'h3C, 1'b0);
    @(negedge clk);
    check("dut2 done_one_cycle", frame_done[2], 1'b0);

    // Back-to-back frames with in_valid held: one idle clock between them.
    start_tx(0, 8'h00);
    in_data[0] = 8'hFF;
    expect_frame(0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    expect_frame(0, 8'hFF, 1'b0);
    @(negedge clk);
    check("dut0 b2b_no_extra_busy", busy[0], 1'b0);
    check("dut0 b2b_done_cleared", frame_done[0], 1'b0);

    // Inputs churn while busy: captured word must be transmitted unchanged.
    start_tx(0, 8'h5A);
    expect_frame(0, 8'h5A, 1'b1);
    @(negedge clk);
    check("dut0 churn_no_extra_accept", busy[0], 1'b0);

    // Reset during data bit 3, then a clean frame right after release.
    start_tx(0, 8'hA5);
    in_valid[0] = 1'b0;
    build(0, 8'hA5);
    expect_bits(0, 5, 1'b0);
    @(posedge clk);
    #1;
    check("dut0 bit3_before_reset", dataout[0], exp_q.pop_front());
    rst_n = 1'b0;
    #1;
    check("dut0 abort_dataout", dataout[0], 1'b1);
    check("dut0 abort_busy", busy[0], 1'b0);
    check("dut0 abort_frame_done", frame_done[0], 1'b0);
    check("dut0 abort_in_ready", in_ready[0], 1'b0);
    exp_q.delete();
    @(negedge clk);
    check("dut0 in_reset_frame_done", frame_done[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    start_tx(0, 8'h3C);
    in_valid[0] = 1'b0;
    expect_frame(0, 8'h3C, 1'b0);
    @(negedge clk);
    check("dut0 post_reset_done_cleared", frame_done[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
